// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the 8-bit ALU, its command driver and
// anything that talks to them. The opcode encoding is fixed by the ALU.
`timescale 1ns/1ps

package alu_pkg;

   // Operand and result width of the ALU; the driver never widens results.
   localparam int DATA_W = 8;

   // ALU opcodes. Shift amounts are taken by the ALU from B[2:0].
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_SHL = 3'b010,
      ALU_SHR = 3'b011,
      ALU_AND = 3'b100,
      ALU_OR  = 3'b101,
      ALU_XOR = 3'b110,
      ALU_EQ  = 3'b111
   } alu_op_e;

   // One issued operation as presented to the ALU inputs.
   typedef struct packed {
      alu_op_e             op;
      logic [DATA_W-1:0]   a;
      logic [DATA_W-1:0]   b;
   } alu_issue_t;

   // Width needed to hold an occupancy value of 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : alu_pkg

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: small synchronous FIFO holding captured ALU results until
// the consumer takes them. DEPTH must be a power of two so the pointers
// wrap naturally. A push and a pop in the same cycle keep the count steady
// and the pop sees the old head (read-first).
`timescale 1ns/1ps

module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int W      = DATA_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push_i,
   input  logic [W-1:0]                  push_data_i,
   input  logic                          pop_i,
   output logic [W-1:0]                  pop_data_o,
   output logic [cnt_width(DEPTH)-1:0]   count_o,
   output logic                          empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [W-1:0]      mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;
   logic              full;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty_o = (count == '0);
   assign count_o = count;

   // A pop is only honoured when there is data; a push is only honoured
   // when a slot is free or is being freed in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full || do_pop);

   // Head entry, forced to zero when empty so no stale data is visible.
   assign pop_data_o = empty_o ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; the pointers and
      // count are, and the empty gating on pop_data_o hides stale contents.
      if (do_push) mem[wr_ptr] <= push_data_i;
   end

endmodule : alu_res_fifo

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: two-stage front end for the combinational 8-bit ALU.
// Stage 1 registers an accepted command onto the ALU inputs; stage 2
// captures the ALU result into the result FIFO and the accumulator.
// Chained accumulator commands see an in-flight result via forwarding.
`timescale 1ns/1ps

module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   // command side
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [2:0]         cmd_op_i,
   input  logic [DATA_W-1:0]  cmd_a_i,
   input  logic [DATA_W-1:0]  cmd_b_i,
   input  logic               cmd_acc_i,
   // ALU side
   output logic [2:0]         alu_op_o,
   output logic [DATA_W-1:0]  alu_a_o,
   output logic [DATA_W-1:0]  alu_b_o,
   input  logic [DATA_W-1:0]  alu_res_i,
   // result side
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [DATA_W-1:0]  res_data_o,
   output logic [DATA_W-1:0]  acc_o
);

   localparam int CNT_W = cnt_width(DEPTH);

   alu_issue_t          issue_q;
   alu_issue_t          issue_d;
   logic                s1_valid;
   logic [DATA_W-1:0]   acc_q;
   logic [DATA_W-1:0]   acc_eff;
   logic                accept;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W:0]      slots_used;

   // Slots already spoken for: entries held plus the result still in the
   // ALU. A same-cycle pop is not counted, which keeps res_ready_i off the
   // cmd_ready_o path.
   assign slots_used  = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid);
   assign cmd_ready_o = (slots_used < (CNT_W+1)'(DEPTH));
   assign accept      = cmd_valid_i && cmd_ready_o;

   // The accumulator value a new command should see: the result being
   // captured this edge wins over the stored accumulator.
   assign acc_eff = s1_valid ? alu_res_i : acc_q;

   // Next issue contents built from the incoming command.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      issue_d    = issue_q;
      issue_d.op = alu_op_e'(cmd_op_i);
      issue_d.a  = cmd_acc_i ? acc_eff : cmd_a_i;
      issue_d.b  = cmd_b_i;
   end

   // Stage 1: load the ALU input registers on accept, hold otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_q  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) issue_q <= issue_d;
      end
   end

   // Stage 2: the accumulator follows every captured result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else if (s1_valid) begin
         acc_q <= alu_res_i;
      end
   end

   assign alu_op_o = issue_q.op;
   assign alu_a_o  = issue_q.a;
   assign alu_b_o  = issue_q.b;
   assign acc_o    = acc_q;

   // Stage 2 capture into the result FIFO; the credit check above
   // guarantees a free slot for every push.
   alu_res_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_res_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (s1_valid),
      .push_data_i (alu_res_i),
      .pop_i       (res_ready_i),
      .pop_data_o  (res_data_o),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty)
   );

   assign res_valid_o = !fifo_empty;

endmodule : alu_cmd_driver

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: scoreboard bench for alu_cmd_driver. The bench plays
// the role of the combinational ALU, predicts each result when a command is
// accepted, and a separate monitor compares results as they are popped.
`timescale 1ns/1ps

module tb_alu_cmd_driver;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [2:0]  cmd_op_i = '0;
   logic [7:0]  cmd_a_i = '0;
   logic [7:0]  cmd_b_i = '0;
   logic        cmd_acc_i = 1'b0;
   logic [2:0]  alu_op_o;
   logic [7:0]  alu_a_o;
   logic [7:0]  alu_b_o;
   logic [7:0]  alu_res_i;
   logic        res_valid_o;
   logic        res_ready_i = 1'b0;
   logic [7:0]  res_data_o;
   logic [7:0]  acc_o;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  pop_log[$];
   logic [7:0]  m_acc = '0;
   int          ready_mode = 0;   // 0: never ready, 1: always ready, 2: random

   alu_cmd_driver #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_a_i     (cmd_a_i),
      .cmd_b_i     (cmd_b_i),
      .cmd_acc_i   (cmd_acc_i),
      .alu_op_o    (alu_op_o),
      .alu_a_o     (alu_a_o),
      .alu_b_o     (alu_b_o),
      .alu_res_i   (alu_res_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_data_o  (res_data_o),
      .acc_o       (acc_o)
   );

   always #5 clk = ~clk;

   // The ALU's documented behaviour, used both as the bench's ALU and as
   // the arithmetic of the reference model.
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a << b[2:0];
         3'b011:  return a >> b[2:0];
         3'b100:  return a & b;
         3'b101:  return a | b;
         3'b110:  return a ^ b;
         default: return (a == b) ? 8'h01 : 8'h00;
      endcase
   endfunction

   always_comb alu_res_i = alu_f(alu_op_o, alu_a_o, alu_b_o);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_log(input string name, input int idx, input logic [7:0] exp);
      if (idx < pop_log.size()) begin
         check(name, pop_log[idx], exp);
      end else begin
         checks++;
         failures++;
         $display("FAIL %s: result %0d never popped, expected 0x%0h", name, idx, exp);
      end
   endtask

   // Consumer ready, changed just after the rising edge.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       res_ready_i = 1'b0;
         1:       res_ready_i = 1'b1;
         default: res_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every handshake-completing result is compared against the
   // oldest prediction.
   always @(negedge clk) begin
      if (reset_n && res_valid_o && res_ready_i) begin
         pop_log.push_back(res_data_o);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got 0x%0h with nothing outstanding", res_data_o);
         end else begin
            check("result", res_data_o, exp_q.pop_front());
         end
      end
   end

   // Reference model: the accumulator always holds the most recent
   // accepted command's result, so it is what an acc command uses as A.
   function automatic void model_accept(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic use_acc);
      logic [7:0] r;
      r = alu_f(op, use_acc ? m_acc : a, b);
      m_acc = r;
      exp_q.push_back(r);
   endfunction

   // Present one command and return just after the edge that accepted it.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic use_acc);
      int n;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_a_i     = a;
      cmd_b_i     = b;
      cmd_acc_i   = use_acc;
      n = 0;
      while (!cmd_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready_o) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: cmd_ready_o stuck low");
         cmd_valid_i = 1'b0;
         return;
      end
      model_accept(op, a, b, use_acc);
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic idle(input int cycles);
      cmd_valid_i = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Let the consumer take everything and confirm nothing is left over.
   task automatic drain();
      int n;
      ready_mode = 1;
      n = 0;
      while ((exp_q.size() != 0 || res_valid_o) && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("drain_outstanding", exp_q.size(), 0);
      check("acc_after_drain", acc_o, m_acc);
   endtask

   initial begin
      int accepted;

      // Reset held with inputs moving: everything reads zero.
      reset_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         cmd_valid_i = 1'($urandom_range(0, 1));
         cmd_op_i    = 3'($urandom);
         cmd_a_i     = 8'($urandom);
         cmd_b_i     = 8'($urandom);
         cmd_acc_i   = 1'($urandom_range(0, 1));
      end
      #1;
      check("rst_res_valid", res_valid_o, 0);
      check("rst_res_data", res_data_o, 0);
      check("rst_acc", acc_o, 0);
      check("rst_alu_op", alu_op_o, 0);
      check("rst_alu_a", alu_a_o, 0);
      check("rst_alu_b", alu_b_o, 0);
      cmd_valid_i = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_rst_cmd_ready", cmd_ready_o, 1);
      check("post_rst_res_valid", res_valid_o, 0);
      check("post_rst_acc", acc_o, 0);

      // Single ADD: inputs one cycle after accept, result one cycle later.
      ready_mode = 0;
      pop_log.delete();
      send(3'b000, 8'h03, 8'h05, 1'b0);
      check("add_alu_op", alu_op_o, 3'b000);
      check("add_alu_a", alu_a_o, 8'h03);
      check("add_alu_b", alu_b_o, 8'h05);
      check("add_not_yet_valid", res_valid_o, 0);
      @(posedge clk);
      #1;
      check("add_res_valid", res_valid_o, 1);
      check("add_res_data", res_data_o, 8'h08);
      check("add_acc", acc_o, 8'h08);
      drain();
      check_log("add_popped", 0, 8'h08);

      // Back-to-back accumulator chain uses the forwarded result.
      pop_log.delete();
      send(3'b000, 8'h0A, 8'h14, 1'b0);
      send(3'b001, 8'hEE, 8'h05, 1'b1);
      check("chain_alu_op", alu_op_o, 3'b001);
      check("chain_fwd_a", alu_a_o, 8'h1E);
      drain();
      check_log("chain_res0", 0, 8'h1E);
      check_log("chain_res1", 1, 8'h19);
      check("chain_acc", acc_o, 8'h19);

      // Backpressure: valid held six cycles, only DEPTH get in.
      ready_mode = 0;
      accepted = 0;
      repeat (6) begin
         @(negedge clk);
         cmd_valid_i = 1'b1;
         cmd_op_i    = 3'($urandom);
         cmd_a_i     = 8'($urandom);
         cmd_b_i     = 8'($urandom);
         cmd_acc_i   = 1'b0;
         if (cmd_ready_o) begin
            accepted++;
            model_accept(cmd_op_i, cmd_a_i, cmd_b_i, 1'b0);
         end
      end
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      check("bp_accepted", accepted, DEPTH);
      check("bp_full_ready", cmd_ready_o, 0);
      check("bp_res_valid", res_valid_o, 1);
      ready_mode = 1;
      @(posedge clk);
      #2;
      check("bp_ready_ignores_pop", cmd_ready_o, 0);
      @(posedge clk);
      #2;
      check("bp_ready_after_pop", cmd_ready_o, 1);
      drain();

      // Ops sweep through the ALU.
      pop_log.delete();
      send(3'b111, 8'h5A, 8'h5A, 1'b0);
      send(3'b010, 8'h81, 8'h0A, 1'b0);
      send(3'b110, 8'hF0, 8'hFF, 1'b0);
      send(3'b001, 8'h00, 8'h01, 1'b0);
      drain();
      check_log("sweep_eq", 0, 8'h01);
      check_log("sweep_shl", 1, 8'h04);
      check_log("sweep_xor", 2, 8'h0F);
      check_log("sweep_sub_wrap", 3, 8'hFF);
      check("sweep_acc", acc_o, 8'hFF);

      // Randomised traffic with a random consumer.
      ready_mode = 2;
      for (int i = 0; i < 200; i++) begin
         send(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Reset mid-operation: two queued, one in flight.
      ready_mode = 0;
      send(3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      send(3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      send(3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      check("mid_queued_valid", res_valid_o, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_res_valid", res_valid_o, 0);
      check("mid_rst_acc", acc_o, 0);
      check("mid_rst_res_data", res_data_o, 0);
      check("mid_rst_alu_a", alu_a_o, 0);
      exp_q.delete();
      m_acc = '0;
      #3;
      reset_n = 1'b1;
      ready_mode = 1;
      repeat (6) @(posedge clk);
      #2;
      check("no_stale_valid", res_valid_o, 0);
      check("no_stale_acc", acc_o, 0);
      pop_log.delete();
      send(3'b000, 8'h01, 8'h02, 1'b1);
      drain();
      check_log("post_mid_rst_res", 0, 8'h02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_alu_cmd_driver
